// File: rtl/ifm_pkt_fifo.sv
// Receive packet FIFO: beats are stored speculatively and a frame is released to the
// AXI-stream side only when its last beat commits it; bad or overflowing frames roll back in place.
module ifm_pkt_fifo #(
  parameter int DATA_W       = 64,
  parameter int KEEP_W       = DATA_W / 8,
  parameter int ADDR_W       = 9,
  parameter int AFULL_THRESH = (2 ** ADDR_W) - 16
) (
  input  logic              s2mm_clk,
  input  logic              s2mm_rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [KEEP_W-1:0] wr_keep,
  input  logic              wr_last,
  input  logic              wr_bad,
  input  logic              wr_en,
  output logic              wr_afull,
  output logic              wr_overflow,
  output logic [DATA_W-1:0] rxd_tdata,
  output logic [KEEP_W-1:0] rxd_tkeep,
  output logic              rxd_tlast,
  output logic              rxd_tvalid,
  input  logic              rxd_tready,
  output logic [ADDR_W:0]   frm_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int MW    = DATA_W + KEEP_W + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_AFULL = PW'(AFULL_THRESH);

  typedef enum logic [0:0] {ACCEPT = 1'b0, DISCARD = 1'b1} wr_state_t;

  wr_state_t     state_r, state_nxt_s;
  logic [PW-1:0] wptr_r, cptr_r, rptr_r, used_s;
  logic          full_s, wr_s, commit_s, rollback_s, ovf_s;
  logic          rd_s, out_ready_s, pend_r, last_hs_s;
  logic [MW-1:0] mem_r [DEPTH];
  logic [MW-1:0] ram_q_r;
  logic [PW-1:0] frm_cnt_r;
  logic [15:0]   drop_cnt_r;
  logic [DATA_W-1:0] tdata_r;
  logic [KEEP_W-1:0] tkeep_r;
  logic          tlast_r, tvalid_r, afull_r, overflow_r;

  assign used_s      = wptr_r - rptr_r;
  assign full_s      = (used_s == PTR_DEPTH);
  assign out_ready_s = !tvalid_r || rxd_tready;
  assign rd_s        = (rptr_r != cptr_r) && out_ready_s;
  assign last_hs_s   = tvalid_r && rxd_tready && tlast_r;

  // Write FSM state register
  always_ff @(posedge s2mm_clk) begin
    if (s2mm_rst) begin
      state_r <= ACCEPT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Write FSM next state: a refused non-last beat poisons the rest of its frame
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACCEPT: begin
        if (wr_en && full_s && !wr_last) state_nxt_s = DISCARD;
        else                             state_nxt_s = ACCEPT;
      end
      DISCARD: begin
        if (wr_en && wr_last) state_nxt_s = ACCEPT;
        else                  state_nxt_s = DISCARD;
      end
      default: state_nxt_s = ACCEPT;
    endcase
  end

  // Write FSM outputs: store, commit, rollback and overflow strobes
  always_comb begin
    wr_s       = 1'b0;
    commit_s   = 1'b0;
    rollback_s = 1'b0;
    ovf_s      = 1'b0;
    case (state_r)
      ACCEPT: begin
        if (wr_en && !full_s) begin
          wr_s       = 1'b1;
          commit_s   = wr_last && !wr_bad;
          rollback_s = wr_last && wr_bad;
        end else if (wr_en) begin
          ovf_s      = 1'b1;
          rollback_s = wr_last;
        end else begin
          wr_s = 1'b0;
        end
      end
      DISCARD: begin
        rollback_s = wr_en && wr_last;
      end
      default: begin
        wr_s = 1'b0;
      end
    endcase
  end

  // Frame storage with registered read port
  always_ff @(posedge s2mm_clk) begin
    if (wr_s) mem_r[wptr_r[ADDR_W-1:0]] <= {wr_last, wr_keep, wr_data};
    if (rd_s) ram_q_r <= mem_r[rptr_r[ADDR_W-1:0]];
  end

  // Pointers; rollback wins over the increment of the beat carrying the bad status
  always_ff @(posedge s2mm_clk) begin
    if (s2mm_rst) begin
      wptr_r <= '0;
      cptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (rollback_s)  wptr_r <= cptr_r;
      else if (wr_s)   wptr_r <= wptr_r + PTR_ONE;
      if (commit_s)    cptr_r <= wptr_r + PTR_ONE;
      if (rd_s)        rptr_r <= rptr_r + PTR_ONE;
    end
  end

  // Output register fed by the RAM read stage; together they form a 2-entry pipeline
  always_ff @(posedge s2mm_clk) begin
    if (s2mm_rst) begin
      pend_r   <= 1'b0;
      tvalid_r <= 1'b0;
      tdata_r  <= '0;
      tkeep_r  <= '0;
      tlast_r  <= 1'b0;
    end else if (out_ready_s) begin
      pend_r   <= rd_s;
      tvalid_r <= pend_r;
      if (pend_r) {tlast_r, tkeep_r, tdata_r} <= ram_q_r;
    end
  end

  // Status counters and flags
  always_ff @(posedge s2mm_clk) begin
    if (s2mm_rst) begin
      frm_cnt_r  <= '0;
      drop_cnt_r <= 16'd0;
      afull_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case ({commit_s, last_hs_s})
        2'b10:   frm_cnt_r <= frm_cnt_r + PTR_ONE;
        2'b01:   frm_cnt_r <= frm_cnt_r - PTR_ONE;
        default: frm_cnt_r <= frm_cnt_r;
      endcase
      if (rollback_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
      afull_r    <= (used_s >= PTR_AFULL);
      overflow_r <= ovf_s;
    end
  end

  assign wr_afull    = afull_r;
  assign wr_overflow = overflow_r;
  assign rxd_tdata   = tdata_r;
  assign rxd_tkeep   = tkeep_r;
  assign rxd_tlast   = tlast_r;
  assign rxd_tvalid  = tvalid_r;
  assign frm_cnt     = frm_cnt_r;
  assign drop_cnt    = drop_cnt_r;

endmodule

// File: doc/ifm_pkt_fifo.md
# ifm_pkt_fifo

Parametrised single-clock receive packet FIFO for the 10GbE s2mm path. It is the next generation of the rx good-frame buffer. Beats are written speculatively and a frame becomes visible on the AXI-stream read side only once its last beat commits it as good. Bad frames and frames that overflow the buffer are rolled back in place, so no downstream discard logic is needed. It also reports pending-frame and dropped-frame counts for the DMA/status logic.

## Interface
Parameters:
- DATA_W, 64, data width in bits; multiple of 8.
- KEEP_W, DATA_W/8, byte-enable width.
- ADDR_W, 9, log2 of depth; DEPTH = 2^ADDR_W beats.
- AFULL_THRESH, 2^ADDR_W-16, speculative occupancy at which wr_afull asserts.

Ports:
- s2mm_clk  in  1  clock.
- s2mm_rst  in  1  reset; one clock; reset is synchronous and active-high.
- wr_data  in  DATA_W  write beat data.
- wr_keep  in  KEEP_W  write beat byte enables.
- wr_last  in  1  last beat of frame.
- wr_bad  in  1  frame status; sampled only with wr_en&&wr_last; 1 means drop.
- wr_en  in  1  beat valid; no backpressure on the write side.
- wr_afull  out  1  registered; speculative occupancy >= AFULL_THRESH.
- wr_overflow  out  1  one-cycle pulse when a beat is refused because the FIFO is full.
- rxd_tdata  out  DATA_W  AXI-S data.
- rxd_tkeep  out  KEEP_W  AXI-S keep.
- rxd_tlast  out  1  AXI-S last.
- rxd_tvalid  out  1  AXI-S valid.
- rxd_tready  in  1  AXI-S ready.
- frm_cnt  out  ADDR_W+1  committed frames not yet fully read.
- drop_cnt  out  16  frames dropped (bad or overflow); saturates at 0xFFFF.

## Operation
- Storage: DEPTH x (DATA_W+KEEP_W+1) RAM with synchronous read, plus one output register.
- Pointers are ADDR_W+1 bits wide, and the MSB handles wrap:
  - wptr: speculative write pointer.
  - cptr: commit pointer.
  - rptr: read pointer.
- full = (wptr-rptr)==DEPTH.
- Write FSM has two states, ACCEPT and DISCARD.
- ACCEPT, wr_en and not full:
  - Write the beat at wptr, then wptr++.
  - If wr_last and !wr_bad: cptr <= wptr+1 and frm_cnt++ (commit).
  - If wr_last and wr_bad: wptr <= cptr and drop_cnt++ (rollback).
- ACCEPT, wr_en and full:
  - The beat is not written and wr_overflow pulses.
  - If wr_last: rollback and drop_cnt++ in this cycle; stay in ACCEPT.
  - Otherwise: go to DISCARD.
- DISCARD:
  - All beats are ignored, and wr_overflow does not pulse again.
  - On wr_en&&wr_last: rollback, drop_cnt++, go to ACCEPT. wr_bad is ignored.
- A frame longer than DEPTH is always dropped.
- Read side:
  - RAM is read at rptr when rptr!=cptr and the output register is empty or being consumed (tvalid&&tready); rptr++ on that read.
  - The output register loads one cycle later; tvalid stays high until handshake.
- frm_cnt--:
  - Decrements on a handshake with tlast=1.
  - If a commit and a tlast handshake occur in the same cycle, frm_cnt is unchanged.
- Rollback never crosses rptr, since rptr never passes cptr.
- Reset values:
  - Pointers, frm_cnt and drop_cnt are 0; FSM is in ACCEPT.
  - rxd_tvalid, wr_afull and wr_overflow are 0; rxd_tdata, tkeep and tlast are 0.
  - A frame in flight at reset is lost; the next beat starts a new frame.

## Timing
- Commit to visibility: wr_last accepted at edge k updates cptr at k. The RAM read is issued in cycle k+1, and rxd_tvalid is high after edge k+2 if the read side was idle.
- Streaming: back-to-back reads with tready held high give 1 beat/cycle with no bubbles. The output register plus a registered RAM read form a 2-entry pipeline.
- wr_afull reflects occupancy one cycle after the write/read that crosses the threshold.
- Frees: a read frees a slot for full one cycle after the RAM read.
- Rollback frees slots in the same cycle.

## Test plan
- ADDR_W=4, good frame: write a 3-beat good frame (wr_last on beat 3). rxd_tvalid asserts 2 cycles after beat 3, and the 3 beats appear in order with tlast on beat 3. frm_cnt goes 0->1->0.
- Bad frame: write a 4-beat frame with wr_bad=1, then a 2-beat good frame. Only the 2-beat frame appears, drop_cnt=1, and wptr==cptr after the bad frame.
- Overflow, ADDR_W=4, tready=0: write a 20-beat frame. wr_overflow pulses once, at beat 17. The frame is dropped, drop_cnt=1 and tvalid stays 0. A following 2-beat frame is then accepted and read out.
- Wrap and streaming: 40 frames of 5 beats with tready random at 50%. Data arrives bit-exact with pointer wrap, and frm_cnt never exceeds 3.
- Simultaneous events: a commit in the same cycle as a tlast handshake leaves frm_cnt unchanged. Checked with frm_cnt=1 before and after. wr_afull asserts at occupancy 12 when AFULL_THRESH=12.
- Reset mid-operation: assert s2mm_rst during beat 2 of a frame while tvalid=1. All outputs and counters are 0 the cycle after, and a fresh 1-beat frame then reads back correctly.
